// File: rtl/masked_rand_pkg.sv
// masked_rand_pkg: shared state encoding and data widths for the randomness manager
package masked_rand_pkg;
  localparam int RAND_W = 64;
  localparam int SEED_W = 128;
  typedef enum logic [2:0] {IDLE, INIT, WARMUP, RUN, WAIT_SEED} rand_state_e;
endpackage

// File: rtl/rand_fifo.sv
// rand_fifo: DEPTH x 64-bit synchronous FIFO with zero-latency head read
// ports: clk, rst (async), push/pop/flush strobes, din -> dout (head, 0 when empty),
//        level (occupancy), full, empty
module rand_fifo
  import masked_rand_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [RAND_W-1:0] din,
  output logic [RAND_W-1:0] dout,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [RAND_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic push_ok, pop_ok;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      wr <= wr + AW'(push_ok);
      rd <= rd + AW'(pop_ok);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  always_ff @(posedge clk)
    if (push_ok && !flush) mem[wr] <= din;
endmodule

// File: rtl/masked_rand_ctrl.sv
// masked_rand_ctrl: PRNG seeding/stepping manager feeding a word FIFO for masked gadgets
// ports: clk, rst (async); seed_valid_i/seed_i/seed_ready_o/seed_err_o seed handshake;
//        reseed_req_o; prng_init_o/prng_en_o/prng_seed_o/prng_data_i PRNG link;
//        flush_i; rnd_valid_o/rnd_ready_i/rnd_o/level_o consumer side
module masked_rand_ctrl
  import masked_rand_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STEPS_PER_WORD = 64,
  parameter int WARMUP_STEPS = 128,
  parameter int RESEED_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seed_valid_i,
  input  logic [SEED_W-1:0]            seed_i,
  output logic                         seed_ready_o,
  output logic                         seed_err_o,
  output logic                         reseed_req_o,
  output logic                         prng_init_o,
  output logic                         prng_en_o,
  output logic [SEED_W-1:0]            prng_seed_o,
  input  logic [RAND_W-1:0]            prng_data_i,
  input  logic                         flush_i,
  output logic                         rnd_valid_o,
  input  logic                         rnd_ready_i,
  output logic [RAND_W-1:0]            rnd_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int SW = STEPS_PER_WORD > 1 ? $clog2(STEPS_PER_WORD) : 1;
  localparam int WW = WARMUP_STEPS > 1 ? $clog2(WARMUP_STEPS) : 1;
  localparam int RW = RESEED_WORDS > 1 ? $clog2(RESEED_WORDS) : 1;
  rand_state_e state, state_n;
  logic [SEED_W-1:0] seed_q;
  logic [SW-1:0] step;
  logic [WW-1:0] warm;
  logic [RW-1:0] words;
  logic full, empty, push, seed_take, seed_ok, word_hit;
  // ready is held low while reset is asserted so every output reads 0 in reset
  assign seed_ready_o = !rst && (state == IDLE || state == WAIT_SEED);
  assign seed_take = seed_valid_i && seed_ready_o;
  assign seed_ok = seed_take && seed_i != '0;
  assign reseed_req_o = state == WAIT_SEED;
  assign prng_init_o = state == INIT;
  // enable depends only on registered state, never on rnd_ready_i
  assign prng_en_o = state == WARMUP || (state == RUN && !full);
  assign prng_seed_o = seed_q;
  assign push = state == RUN && !full && step == SW'(STEPS_PER_WORD - 1);
  assign word_hit = push && RESEED_WORDS != 0 && words == RW'(RESEED_WORDS - 1);
  assign rnd_valid_o = !empty;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, WAIT_SEED: state_n = seed_ok ? INIT : state;
      INIT:            state_n = WARMUP_STEPS == 0 ? RUN : WARMUP;
      WARMUP:          state_n = warm == WW'(WARMUP_STEPS - 1) ? RUN : WARMUP;
      RUN:             state_n = word_hit ? WAIT_SEED : RUN;
      default:         state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      seed_q <= '0;
      step <= '0;
      warm <= '0;
      words <= '0;
      seed_err_o <= 1'b0;
    end else begin
      state <= state_n;
      seed_err_o <= seed_take && seed_i == '0;
      seed_q <= seed_ok ? seed_i : seed_q;
      step <= (state == INIT || push) ? '0 : step + SW'(state == RUN && !full);
      warm <= state == INIT ? '0 : warm + WW'(state == WARMUP);
      words <= word_hit ? '0 : words + RW'(push);
    end
  rand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(rnd_ready_i),
    .flush(flush_i),
    .din(prng_data_i),
    .dout(rnd_o),
    .level(level_o),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_masked_rand_ctrl.sv
// tb_masked_rand_ctrl: three configurations checked against a count-based model plus directed literals
module tb_masked_rand_ctrl;
  localparam int N = 3;
  localparam int DP = 4;
  localparam int ST [N] = '{1, 64, 1};
  localparam int WU [N] = '{0, 128, 0};
  localparam int RS [N] = '{0, 6, 3};
  logic clk = 0;
  logic rst;
  logic sv [N];
  logic [127:0] sd [N];
  logic fl [N], rr [N];
  logic srdy [N], serr [N], rreq [N], pin [N], pen [N], rv [N];
  logic [127:0] pseed [N];
  logic [63:0] ro [N], ps [N];
  logic [2:0] lv [N];
  int n_chk = 0, n_fail = 0;
  int mode [N], ec [N], wc [N];
  logic [127:0] mseed [N];
  bit merr [N];
  logic [63:0] mq [N][$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : d
    masked_rand_ctrl #(.DEPTH(DP), .STEPS_PER_WORD(ST[g]), .WARMUP_STEPS(WU[g]),
                       .RESEED_WORDS(RS[g])) u (
      .clk(clk), .rst(rst), .seed_valid_i(sv[g]), .seed_i(sd[g]),
      .seed_ready_o(srdy[g]), .seed_err_o(serr[g]), .reseed_req_o(rreq[g]),
      .prng_init_o(pin[g]), .prng_en_o(pen[g]), .prng_seed_o(pseed[g]),
      .prng_data_i(ps[g]), .flush_i(fl[g]), .rnd_valid_o(rv[g]),
      .rnd_ready_i(rr[g]), .rnd_o(ro[g]), .level_o(lv[g]));
  end
  function automatic logic [63:0] nx(input logic [63:0] x);
    return {x[62:0], ~x[63]};
  endfunction
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (pin[i]) ps[i] <= nx(pseed[i][63:0]);
      else if (pen[i]) ps[i] <= nx(ps[i]);
  function automatic bit ex_en(input int i);
    return mode[i] == 2 && (ec[i] < WU[i] || mq[i].size() < DP);
  endfunction
  function automatic bit ex_push(input int i);
    return mode[i] == 2 && ec[i] >= WU[i] && mq[i].size() < DP && (ec[i] - WU[i]) % ST[i] == ST[i] - 1;
  endfunction
  always @(posedge clk or posedge rst)
    for (int i = 0; i < N; i++) begin : mdl
      bit en, pu, po, acc;
      if (rst) begin
        mode[i] = 0; ec[i] = 0; wc[i] = 0; mseed[i] = '0; merr[i] = 0;
        mq[i].delete();
      end else begin
        en = ex_en(i);
        pu = ex_push(i);
        po = rr[i] && mq[i].size() > 0;
        acc = (mode[i] == 0 || mode[i] == 3) && sv[i];
        if (fl[i]) mq[i].delete();
        else begin
          if (po) void'(mq[i].pop_front());
          if (pu) mq[i].push_back(ps[i]);
        end
        if (en) ec[i]++;
        if (pu) begin
          wc[i]++;
          if (RS[i] != 0 && wc[i] == RS[i]) begin mode[i] = 3; wc[i] = 0; end
        end
        merr[i] = acc && sd[i] == '0;
        if (mode[i] == 1) begin mode[i] = 2; ec[i] = 0; end
        else if (acc && sd[i] != '0) begin mode[i] = 1; mseed[i] = sd[i]; end
      end
    end
  task automatic chk(input int i, input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, i, $time, a, e);
    end
  endtask
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < N; i++) begin
        chk(i, "m_seed_ready", srdy[i], mode[i] == 0 || mode[i] == 3);
        chk(i, "m_seed_err", serr[i], merr[i]);
        chk(i, "m_reseed_req", rreq[i], mode[i] == 3);
        chk(i, "m_init", pin[i], mode[i] == 1);
        chk(i, "m_en", pen[i], ex_en(i));
        chk(i, "m_seed", pseed[i], mseed[i]);
        chk(i, "m_valid", rv[i], mq[i].size() > 0);
        chk(i, "m_level", lv[i], mq[i].size());
        if (mq[i].size() > 0) chk(i, "m_data", ro[i], mq[i][0]);
      end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int cnt;
    for (int i = 0; i < N; i++) begin sv[i] = 0; sd[i] = '0; fl[i] = 0; rr[i] = 0; end
    rst = 1;
    cyc(2);
    for (int i = 0; i < N; i++) begin
      chk(i, "rst_ready", srdy[i], 0);
      chk(i, "rst_en", pen[i], 0);
      chk(i, "rst_level", lv[i], 0);
    end
    #1 rst = 0;
    cyc(1);
    chk(0, "post_rst_ready", srdy[0], 1);
    sv[2] = 1; sd[2] = '0;
    cyc(1);
    sv[2] = 0;
    chk(2, "zs_err", serr[2], 1);
    chk(2, "zs_ready", srdy[2], 1);
    chk(2, "zs_init", pin[2], 0);
    cyc(1);
    chk(2, "zs_err_drop", serr[2], 0);
    chk(2, "zs_init2", pin[2], 0);
    sv[0] = 1; sd[0] = 128'h1;
    cyc(1);
    sv[0] = 0;
    chk(0, "b_init", pin[0], 1);
    chk(0, "b_seed", pseed[0], 128'h1);
    cyc(1);
    chk(0, "b_en", pen[0], 1);
    chk(0, "b_lvl0", lv[0], 0);
    cyc(1);
    chk(0, "b_w0", ro[0], 64'h3);
    chk(0, "b_lvl1", lv[0], 1);
    cyc(1);
    chk(0, "b_lvl2", lv[0], 2);
    cyc(1);
    chk(0, "b_lvl3", lv[0], 3);
    chk(0, "b_head", ro[0], 64'h3);
    cyc(1);
    chk(0, "b_full", lv[0], 4);
    chk(0, "b_full_en", pen[0], 0);
    rr[0] = 1;
    cyc(1);
    rr[0] = 0;
    chk(0, "p_lvl", lv[0], 3);
    chk(0, "p_en", pen[0], 1);
    chk(0, "p_head", ro[0], 64'h7);
    cyc(1);
    chk(0, "p_refill", lv[0], 4);
    chk(0, "p_en_off", pen[0], 0);
    fl[0] = 1;
    cyc(1);
    fl[0] = 0;
    chk(0, "f_lvl", lv[0], 0);
    chk(0, "f_valid", rv[0], 0);
    cyc(2);
    chk(0, "f_lvl2", lv[0], 2);
    fl[0] = 1; rr[0] = 1;
    cyc(1);
    fl[0] = 0; rr[0] = 0;
    chk(0, "f_override", lv[0], 0);
    cyc(1);
    chk(0, "f_after", lv[0], 1);
    rr[2] = 1; sv[2] = 1; sd[2] = 128'h5;
    cyc(1);
    sv[2] = 0;
    for (int k = 0; k < 20; k++) begin
      if (rreq[2]) break;
      cyc(1);
    end
    chk(2, "rs_req", rreq[2], 1);
    chk(2, "rs_en_off", pen[2], 0);
    chk(2, "rs_lvl", lv[2], 1);
    chk(2, "rs_word", ro[2], 64'h2F);
    cyc(1);
    chk(2, "rs_drain", lv[2], 0);
    sv[2] = 1; sd[2] = 128'h9;
    cyc(1);
    sv[2] = 0;
    chk(2, "rs_init", pin[2], 1);
    chk(2, "rs_req_drop", rreq[2], 0);
    cyc(1);
    chk(2, "rs_en", pen[2], 1);
    cyc(1);
    chk(2, "rs_valid", rv[2], 1);
    chk(2, "rs_new_word", ro[2], 64'h13);
    rr[1] = 1; sv[1] = 1; sd[1] = 128'h1;
    cyc(1);
    sv[1] = 0;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (rv[1]) break;
      if (pen[1]) cnt++;
      cyc(1);
    end
    chk(1, "sc_first", cnt, 192);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (pen[1]) cnt++;
      cyc(1);
      if (rv[1]) break;
    end
    chk(1, "sc_word", cnt, 64);
    rr[1] = 0;
    for (int k = 0; k < 400; k++) begin
      if (lv[1] == 3'd4) break;
      cyc(1);
    end
    chk(1, "sc_full", lv[1], 4);
    for (int k = 0; k < 8; k++) begin
      chk(1, "sc_stall", pen[1], 0);
      cyc(1);
    end
    rr[1] = 1;
    cyc(1);
    rr[1] = 0;
    chk(1, "sc_pop", lv[1], 3);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (lv[1] == 3'd4) break;
      if (pen[1]) cnt++;
      cyc(1);
    end
    chk(1, "sc_resume", cnt, 64);
    chk(1, "sc_reseed", rreq[1], 1);
    sv[1] = 1; sd[1] = 128'h3;
    cyc(1);
    sv[1] = 0;
    chk(1, "ar_init", pin[1], 1);
    cyc(10);
    chk(1, "ar_warm_en", pen[1], 1);
    chk(1, "ar_keep", lv[1], 4);
    #2 rst = 1;
    #1;
    chk(1, "ar_ready", srdy[1], 0);
    chk(1, "ar_err", serr[1], 0);
    chk(1, "ar_req", rreq[1], 0);
    chk(1, "ar_init0", pin[1], 0);
    chk(1, "ar_en", pen[1], 0);
    chk(1, "ar_seed", pseed[1], 0);
    chk(1, "ar_valid", rv[1], 0);
    chk(1, "ar_data", ro[1], 0);
    chk(1, "ar_lvl", lv[1], 0);
    cyc(2);
    #1 rst = 0;
    cyc(1);
    chk(1, "ar_ready_rel", srdy[1], 1);
    for (int k = 0; k < 5; k++) begin
      chk(1, "ar_no_init", pin[1], 0);
      chk(1, "ar_no_en", pen[1], 0);
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
